// File: rtl/codec_mix_pkg.sv
// Shared constants and helpers for the codec sample mixer.
// Pan codes, FSM encoding and the saturation helper.
package codec_mix_pkg;

  localparam logic [1:0] PAN_MUTE  = 2'b00;
  localparam logic [1:0] PAN_LEFT  = 2'b01;
  localparam logic [1:0] PAN_RIGHT = 2'b10;
  localparam logic [1:0] PAN_BOTH  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_SAT   = 2'd2;

  // Clamp v into the signed range of an sw-bit word.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int unsigned        sw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (sw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (sw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/codec_sample_mixer_if.sv
// Bus between the sample sources/codec and the mixer.
// master drives samples and frame requests; slave is the mixer.
interface codec_sample_mixer_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 18,
  parameter int OUT_W    = 24
);

  logic [NUM_CH*SAMPLE_W-1:0] sample_in;
  logic [NUM_CH-1:0]          sample_valid;
  logic [NUM_CH*2-1:0]        weight;
  logic [NUM_CH*2-1:0]        pan;
  logic                       new_frame;
  logic [OUT_W-1:0]           hphone_l;
  logic [OUT_W-1:0]           hphone_r;
  logic                       out_valid;
  logic [NUM_CH-1:0]          overflow;
  logic [NUM_CH-1:0]          underflow;
  logic                       frame_miss;

  modport master (
    output sample_in, sample_valid, weight, pan, new_frame,
    input  hphone_l, hphone_r, out_valid,
    input  overflow, underflow, frame_miss
  );

  modport slave (
    input  sample_in, sample_valid, weight, pan, new_frame,
    output hphone_l, hphone_r, out_valid,
    output overflow, underflow, frame_miss
  );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO.
// A pop on a full FIFO frees the slot for a same-cycle push.
module sample_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr_q];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din;
  end

endmodule

// File: rtl/codec_sample_mixer.sv
// Per-channel FIFOs feeding a weighted, panned stereo mix.
// One channel is accumulated per cycle, then saturated.
module codec_sample_mixer
  import codec_mix_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 18,
  parameter int OUT_W    = 24,
  parameter int DEPTH    = 8
) (
  input logic                  clk,
  input logic                  reset,
  codec_sample_mixer_if.slave  bus
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;
  localparam int CI_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PAD   = OUT_W - SAMPLE_W;

  logic [1:0]              state_q, state_d;
  logic [CI_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0] accl_q, accl_d;
  logic signed [ACC_W-1:0] accr_q, accr_d;
  logic [OUT_W-1:0]        hl_q, hl_d;
  logic [OUT_W-1:0]        hr_q, hr_d;
  logic                    vld_q, vld_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d;
  logic [NUM_CH-1:0]       udf_q, udf_d;
  logic                    miss_q, miss_d;

  logic [NUM_CH-1:0]       pop, full, empty;
  logic [SAMPLE_W-1:0]     dout [NUM_CH];

  logic signed [SAMPLE_W-1:0] cur_s;
  logic signed [SAMPLE_W-1:0] shifted;
  logic [1:0]                 cur_w;
  logic [1:0]                 cur_p;
  logic                       cur_e;
  logic [NUM_CH-1:0]          cur_oh;
  logic signed [ACC_W-1:0]    term;
  logic signed [63:0]         sat_l, sat_r;
  logic [SAMPLE_W-1:0]        sl, sr;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
    sample_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.sample_valid[gi]),
      .pop   (pop[gi]),
      .din   (bus.sample_in[gi*SAMPLE_W +: SAMPLE_W]),
      .dout  (dout[gi]),
      .full  (full[gi]),
      .empty (empty[gi])
    );
  end

  // Select the channel being accumulated this cycle.
  always_comb begin
    cur_s  = '0;
    cur_w  = '0;
    cur_p  = PAN_MUTE;
    cur_e  = 1'b0;
    cur_oh = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (idx_q == CI_W'(c)) begin
        cur_s     = dout[c];
        cur_w     = bus.weight[c*2 +: 2];
        cur_p     = bus.pan[c*2 +: 2];
        cur_e     = empty[c];
        cur_oh[c] = 1'b1;
      end
    end
  end

  assign pop     = (state_q == ST_ACCUM) ? (cur_oh & ~empty) : '0;
  assign shifted = cur_s >>> cur_w;
  assign term    = cur_e ? '0
                 : {{(ACC_W-SAMPLE_W){shifted[SAMPLE_W-1]}}, shifted};

  assign sat_l = saturate(64'(accl_q), SAMPLE_W);
  assign sat_r = saturate(64'(accr_q), SAMPLE_W);
  assign sl    = sat_l[SAMPLE_W-1:0];
  assign sr    = sat_r[SAMPLE_W-1:0];

  // Frame FSM, accumulation and sticky flag next-state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accl_d  = accl_q;
    accr_d  = accr_q;
    hl_d    = hl_q;
    hr_d    = hr_q;
    vld_d   = 1'b0;
    udf_d   = udf_q;
    ovf_d   = ovf_q | (bus.sample_valid & full & ~pop);
    miss_d  = miss_q | (bus.new_frame && state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.new_frame) begin
          accl_d  = '0;
          accr_d  = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (cur_e) udf_d = udf_q | cur_oh;
        if (cur_p == PAN_LEFT || cur_p == PAN_BOTH)
          accl_d = accl_q + term;
        if (cur_p == PAN_RIGHT || cur_p == PAN_BOTH)
          accr_d = accr_q + term;
        if (idx_q == CI_W'(NUM_CH - 1)) state_d = ST_SAT;
        else idx_d = idx_q + 1'b1;
      end
      ST_SAT: begin
        hl_d    = OUT_W'(sl) << PAD;
        hr_d    = OUT_W'(sr) << PAD;
        vld_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      accl_q  <= '0;
      accr_q  <= '0;
      hl_q    <= '0;
      hr_q    <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= '0;
      udf_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      accl_q  <= accl_d;
      accr_q  <= accr_d;
      hl_q    <= hl_d;
      hr_q    <= hr_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.hphone_l   = hl_q;
  assign bus.hphone_r   = hr_q;
  assign bus.out_valid  = vld_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;
  assign bus.frame_miss = miss_q;

endmodule

// File: tb/tb_codec_sample_mixer.sv
// Directed bench for codec_sample_mixer.
// Expected stereo words go to a queue; a monitor checks them.
module tb_codec_sample_mixer;

  localparam int NC = 4;
  localparam int SW = 18;
  localparam int OW = 24;

  typedef struct {
    logic [OW-1:0] l;
    logic [OW-1:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb [$];

  codec_sample_mixer_if #(.NUM_CH(NC), .SAMPLE_W(SW), .OUT_W(OW)) bus ();

  codec_sample_mixer #(
    .NUM_CH   (NC),
    .SAMPLE_W (SW),
    .OUT_W    (OW),
    .DEPTH    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] word(input int v);
    logic [SW-1:0] t;
    t = v[SW-1:0];
    return {t, 6'b0};
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Monitor: every out_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: l=%0h r=%0h",
                 bus.hphone_l, bus.hphone_r);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mix_l", 32'(bus.hphone_l), 32'(e.l));
        chk("mix_r", 32'(bus.hphone_r), 32'(e.r));
      end
    end
  end

  task automatic expect_mix(input int l, input int r);
    exp_t e;
    e.l = word(l);
    e.r = word(r);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input int c, input int v);
    logic [SW-1:0] t;
    t = v[SW-1:0];
    bus.sample_in[c*SW +: SW] = t;
    bus.sample_valid = '0;
    bus.sample_valid[c] = 1'b1;
    tick();
    bus.sample_valid = '0;
  endtask

  // Pulse new_frame and measure cycles until out_valid.
  task automatic frame(input int lat_exp);
    int n;
    bus.new_frame = 1'b1;
    tick();
    bus.new_frame = 1'b0;
    n = 1;
    while (n < 30) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      #1;
      n++;
    end
    if (lat_exp > 0) chk("latency", 32'(n), 32'(lat_exp));
    else chk("timeout", 32'(n < 30), 32'd1);
    tick();
  endtask

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = '0;
    bus.weight       = '0;
    bus.pan          = '0;
    bus.new_frame    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_l", 32'(bus.hphone_l), 32'd0);
    chk("rst_r", 32'(bus.hphone_r), 32'd0);
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_udf", 32'(bus.underflow), 32'd0);
    chk("rst_miss", 32'(bus.frame_miss), 32'd0);
    tick();

    // Single channel, both sides.
    bus.pan = 8'hFF;
    bus.weight = 8'h00;
    push(0, 1000);
    expect_mix(1000, 1000);
    frame(NC + 2);
    chk("t1_udf", 32'(bus.underflow), 32'b1110);
    repeat (3) tick();
    chk("t1_hold_l", 32'(bus.hphone_l), 32'(word(1000)));

    // Weighted negative left, plain right.
    do_reset();
    bus.pan = 8'b00_00_10_01;
    bus.weight = 8'b00_00_00_10;
    push(0, -4000);
    push(1, 800);
    expect_mix(-1000, 800);
    frame(NC + 2);
    chk("t2_ovf", 32'(bus.overflow), 32'd0);
    chk("t2_miss", 32'(bus.frame_miss), 32'd0);

    // Positive and negative saturation.
    do_reset();
    bus.pan = 8'hFF;
    bus.weight = 8'h00;
    for (int c = 0; c < NC; c++) push(c, 131071);
    expect_mix(131071, 131071);
    frame(0);
    for (int c = 0; c < NC; c++) push(c, -131072);
    expect_mix(-131072, -131072);
    frame(0);
    chk("t3_udf", 32'(bus.underflow), 32'd0);

    // Overflow on ch2, then drain in order.
    do_reset();
    bus.pan = 8'b00_11_00_00;
    bus.weight = 8'h00;
    for (int k = 1; k <= 9; k++) push(2, k * 1111 - 5000);
    chk("t4_ovf", 32'(bus.overflow), 32'b0100);
    for (int k = 1; k <= 8; k++) begin
      expect_mix(k * 1111 - 5000, k * 1111 - 5000);
      frame(0);
    end
    chk("t4_udf2_pre", 32'(bus.underflow[2]), 32'd0);
    expect_mix(0, 0);
    frame(0);
    chk("t4_udf2_post", 32'(bus.underflow[2]), 32'd1);

    // Second request while busy is dropped.
    do_reset();
    bus.pan = 8'hFF;
    push(0, 500);
    expect_mix(500, 500);
    bus.new_frame = 1'b1;
    tick();
    bus.new_frame = 1'b0;
    tick();
    bus.new_frame = 1'b1;
    tick();
    bus.new_frame = 1'b0;
    repeat (12) tick();
    chk("t5_miss", 32'(bus.frame_miss), 32'd1);
    chk("t5_drain", 32'(sb.size()), 32'd0);

    // Reset in the middle of accumulation.
    do_reset();
    bus.pan = 8'hFF;
    push(0, 700);
    bus.new_frame = 1'b1;
    tick();
    bus.new_frame = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("t6_l", 32'(bus.hphone_l), 32'd0);
    chk("t6_r", 32'(bus.hphone_r), 32'd0);
    chk("t6_flags",
        32'({bus.overflow, bus.underflow, bus.frame_miss}), 32'd0);
    expect_mix(0, 0);
    frame(NC + 2);
    chk("t6_empty", 32'(bus.underflow), 32'b1111);
    push(0, 300);
    expect_mix(300, 300);
    frame(NC + 2);

    repeat (5) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
